// File: rtl/ha_array_reducer_seq.sv
// Sequential reducer for the four half-adder-array row pairs of the 8x8 approximate multiplier.
// Latches one row set per handshake, adds one weighted row per cycle, then holds the product.
module ha_array_reducer_seq #(
  parameter int OUT_W    = 16,
  parameter int ROW_STEP = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [8:0]       ha_array_0_t,
  input  logic [6:0]       ha_array_0_b,
  input  logic [8:0]       ha_array_1_t,
  input  logic [6:0]       ha_array_1_b,
  input  logic [8:0]       ha_array_2_t,
  input  logic [6:0]       ha_array_2_b,
  input  logic [8:0]       ha_array_3_t,
  input  logic [6:0]       ha_array_3_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] product,
  output logic             overflow
);

  localparam int ACC_W = OUT_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t               state_r, state_s;
  logic [1:0]           cnt_r, cnt_s;
  logic [ACC_W-1:0]     acc_r, acc_s;
  logic [ACC_W-1:0]     row_s;
  logic [OUT_W-1:0]     product_r, product_s;
  logic                 overflow_r, overflow_s;
  logic                 in_ready_r, out_valid_r;
  logic                 load_s;
  logic [3:0][8:0]      t_r;
  logic [3:0][6:0]      b_r;

  // Row value: sum bits at weight 2^i, carry bits at 2^(i+2), whole row scaled by 2^(ROW_STEP*k).
  function automatic logic [ACC_W-1:0] row_value(input logic [8:0] t,
                                                  input logic [6:0] b,
                                                  input logic [1:0] k);
    logic [ACC_W-1:0] base;
    base = ACC_W'(t) + (ACC_W'(b) << 2);
    return base << (ROW_STEP * int'(k));
  endfunction

  // Weighted value of the row pair selected by the cycle counter.
  always_comb begin
    row_s = row_value(t_r[cnt_r], b_r[cnt_r], cnt_r);
  end

  // Next-state, accumulator and result-capture logic.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    acc_s      = acc_r;
    product_s  = product_r;
    overflow_s = overflow_r;
    load_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_s = ACC;
          cnt_s   = 2'd0;
          acc_s   = {ACC_W{1'b0}};
          load_s  = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      ACC: begin
        acc_s = acc_r + row_s;
        cnt_s = cnt_r + 2'd1;
        // The result registers only move here, so they stay frozen through HOLD.
        if (cnt_r == 2'd3) begin
          state_s    = HOLD;
          product_s  = acc_s[OUT_W-1:0];
          overflow_s = acc_s[OUT_W];
        end else begin
          state_s = ACC;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = HOLD;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, counter, accumulator and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= 2'd0;
      acc_r       <= {ACC_W{1'b0}};
      product_r   <= {OUT_W{1'b0}};
      overflow_r  <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      acc_r       <= acc_s;
      product_r   <= product_s;
      overflow_r  <= overflow_s;
      in_ready_r  <= (state_s == IDLE);
      out_valid_r <= (state_s == HOLD);
    end
  end

  // Row vectors are captured only on the accept edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_r <= '0;
      b_r <= '0;
    end else if (load_s) begin
      t_r <= {ha_array_3_t, ha_array_2_t, ha_array_1_t, ha_array_0_t};
      b_r <= {ha_array_3_b, ha_array_2_b, ha_array_1_b, ha_array_0_b};
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign product   = product_r;
  assign overflow  = overflow_r;

endmodule

// File: tb/tb_ha_array_reducer_seq.sv
// Directed self-checking bench for ha_array_reducer_seq: table of row sets plus handshake corner sequences.
module tb_ha_array_reducer_seq;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [3:0][8:0] ha_t = '0;
  logic [3:0][6:0] ha_b = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [15:0]     product;
  logic            overflow;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string           name;
    logic [3:0][8:0] t;
    logic [3:0][6:0] b;
    logic [15:0]     prod;
    logic            ovf;
  } vec_t;

  vec_t vecs[6];

  ha_array_reducer_seq #(.OUT_W(16), .ROW_STEP(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .ha_array_0_t (ha_t[0]),
    .ha_array_0_b (ha_b[0]),
    .ha_array_1_t (ha_t[1]),
    .ha_array_1_b (ha_b[1]),
    .ha_array_2_t (ha_t[2]),
    .ha_array_2_b (ha_b[2]),
    .ha_array_3_t (ha_t[3]),
    .ha_array_3_b (ha_b[3]),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .product      (product),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string nm);
    int i;
    for (i = 0; i < 30; i++) begin
      if (in_ready) break;
      tick();
    end
    check({nm, " in_ready before accept"}, 32'(in_ready), 32'd1);
  endtask

  // Accept one row set, scramble the inputs, and wait until out_valid; returns edges counted from accept.
  task automatic accept_and_wait(input vec_t v, output int lat);
    bit ready_leak;
    wait_idle(v.name);
    ha_t     = v.t;
    ha_b     = v.b;
    in_valid = 1'b1;
    tick();
    in_valid   = 1'b0;
    ha_t       = ~v.t;
    ha_b       = ~v.b;
    lat        = 1;
    ready_leak = 1'b0;
    while (!out_valid && lat < 30) begin
      if (in_ready) ready_leak = 1'b1;
      tick();
      lat++;
    end
    check({v.name, " in_ready low while busy"}, 32'(ready_leak), 32'd0);
  endtask

  task automatic release_output(input string nm);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({nm, " out_valid drop"}, 32'(out_valid), 32'd0);
    check({nm, " in_ready after output"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int lat;
    int accepts[$];
    bit flag;
    logic [15:0] held;

    vecs[0] = '{"t0_lsb",  '{9'h000, 9'h000, 9'h000, 9'h001}, '{7'h00, 7'h00, 7'h00, 7'h00}, 16'd1,    1'b0};
    vecs[1] = '{"b1_lsb",  '{9'h000, 9'h000, 9'h000, 9'h000}, '{7'h00, 7'h00, 7'h01, 7'h00}, 16'd16,   1'b0};
    vecs[2] = '{"t3_lsb",  '{9'h001, 9'h000, 9'h000, 9'h000}, '{7'h00, 7'h00, 7'h00, 7'h00}, 16'd64,   1'b0};
    vecs[3] = '{"t2_msb",  '{9'h000, 9'h100, 9'h000, 9'h000}, '{7'h00, 7'h00, 7'h00, 7'h00}, 16'd4096, 1'b0};
    vecs[4] = '{"all_one", '{9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF}, '{7'h7F, 7'h7F, 7'h7F, 7'h7F}, 16'h5257, 1'b1};
    vecs[5] = '{"mixed",   '{9'h1FF, 9'h000, 9'h003, 9'h0AB}, '{7'h00, 7'h05, 7'h00, 7'h11}, 16'h81FB, 1'b0};

    // Reset state
    tick();
    tick();
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst product", 32'(product), 32'd0);
    check("rst overflow", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    tick();

    // Table-driven vectors with latency check
    for (int k = 0; k < 6; k++) begin
      accept_and_wait(vecs[k], lat);
      check({vecs[k].name, " latency"}, 32'(lat), 32'd5);
      check({vecs[k].name, " out_valid"}, 32'(out_valid), 32'd1);
      check({vecs[k].name, " product"}, 32'(product), 32'(vecs[k].prod));
      check({vecs[k].name, " overflow"}, 32'(overflow), 32'(vecs[k].ovf));
      release_output(vecs[k].name);
    end

    // Backpressure: hold 10 cycles in HOLD
    accept_and_wait(vecs[4], lat);
    held = product;
    check("bp product", 32'(held), 32'h5257);
    flag = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!out_valid || in_ready || product !== held || overflow !== 1'b1) flag = 1'b1;
    end
    check("bp held stable", 32'(flag), 32'd0);
    release_output("bp");

    // Back-to-back accepts are spaced by 6 cycles
    ha_t      = vecs[0].t;
    ha_b      = vecs[0].b;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) accepts.push_back(i);
      tick();
    end
    in_valid = 1'b0;
    check("b2b accept count", 32'(accepts.size()), 32'd4);
    for (int i = 1; i < accepts.size(); i++) begin
      check("b2b spacing", 32'(accepts[i] - accepts[i-1]), 32'd6);
    end
    wait_idle("b2b drain");
    out_ready = 1'b0;

    // Reset during ACC discards the in-flight result
    wait_idle("rst_acc");
    ha_t     = vecs[5].t;
    ha_b     = vecs[5].b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("rst_acc out_valid", 32'(out_valid), 32'd0);
    check("rst_acc in_ready", 32'(in_ready), 32'd1);
    check("rst_acc product", 32'(product), 32'd0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    flag = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) flag = 1'b1;
    end
    out_ready = 1'b0;
    check("rst_acc no output", 32'(flag), 32'd0);

    // Operation resumes normally after the mid-flight reset
    accept_and_wait(vecs[5], lat);
    check("post_rst product", 32'(product), 32'h81FB);
    release_output("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
